// File: rtl/pipe_pkg.sv
// Shared types for the handshaked pipeline stage: skid FSM states and default widths.
package pipe_pkg;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 24;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_of(skid_state_e s);
    case (s)
      S_ONE:   return 2'd1;
      S_FULL:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with sync flush, optional 2-entry skid and stall counter.
// Control payload reads as CTRL_CLR whenever no beat is presented.
module pipe_stage_hs import pipe_pkg::*; #(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              CTRL_W   = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_CLR = '0,
  parameter bit              SKID     = 1'b1,
  parameter bit              DATA_CLR = 1'b1,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              in_xfer, out_xfer, stall_inc;
  logic              main_ld, main_from_skid;
  logic [DATA_W-1:0] skid_data, data_q, data_d;
  logic [CTRL_W-1:0] skid_ctrl, ctrl_q, ctrl_d;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready;

  generate
    if (SKID) begin : g_skid
      skid_state_e       state_q, state_d;
      logic              rdy_q, skid_ld;
      logic [DATA_W-1:0] sd_q;
      logic [CTRL_W-1:0] sc_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
      end

      always_comb begin
        state_d = state_q;
        if (flush) state_d = S_EMPTY;
        else begin
          case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_ONE;
            S_ONE: begin
              if (in_xfer && !out_xfer)      state_d = S_FULL;
              else if (!in_xfer && out_xfer) state_d = S_EMPTY;
            end
            S_FULL:  if (out_xfer) state_d = S_ONE;
            default: state_d = S_EMPTY;
          endcase
        end
      end

      always_comb begin
        out_valid = (state_q != S_EMPTY);
        occupancy = occ_of(state_q);
        in_ready  = rdy_q;
      end

      // Ready is registered from the next state so it never depends on out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b1;
        else     rdy_q <= (state_d != S_FULL);
      end

      assign main_ld        = !flush && in_xfer &&
                              ((state_q == S_EMPTY) || ((state_q == S_ONE) && out_xfer));
      assign main_from_skid = !flush && (state_q == S_FULL) && out_xfer;
      assign skid_ld        = !flush && (state_q == S_ONE) && in_xfer && !out_xfer;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sd_q <= '0;
          sc_q <= CTRL_CLR;
        end else if (flush) begin
          if (DATA_CLR) sd_q <= '0;
          sc_q <= CTRL_CLR;
        end else if (skid_ld) begin
          sd_q <= in_data;
          sc_q <= in_ctrl;
        end
      end

      assign skid_data = sd_q;
      assign skid_ctrl = sc_q;
    end else begin : g_single
      logic vld_q, vld_d;

      assign in_ready = out_ready || !vld_q;

      always_comb begin
        vld_d = vld_q;
        if (flush)         vld_d = 1'b0;
        else if (in_xfer)  vld_d = 1'b1;
        else if (out_xfer) vld_d = 1'b0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
      end

      assign out_valid      = vld_q;
      assign occupancy      = {1'b0, vld_q};
      assign main_ld        = in_xfer;
      assign main_from_skid = 1'b0;
      assign skid_data      = '0;
      assign skid_ctrl      = CTRL_CLR;
    end
  endgenerate

  // Main register shared by both modes; a drained beat leaves data in place but NOPs the control.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (flush) begin
      if (DATA_CLR) data_d = '0;
      ctrl_d = CTRL_CLR;
    end else if (main_ld) begin
      data_d = in_data;
      ctrl_d = in_ctrl;
    end else if (main_from_skid) begin
      data_d = skid_data;
      ctrl_d = skid_ctrl;
    end else if (out_xfer) begin
      ctrl_d = CTRL_CLR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= CTRL_CLR;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign out_data = data_q;
  assign out_ctrl = ctrl_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: instance 1 is SKID=1/DATA_CLR=1, instance 0 is SKID=0/DATA_CLR=0/CNT_W=4.
module tb_pipe_stage_hs;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [CW-1:0] CLR = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] iv, ordy, fl, ir, ov;
  logic [1:0][DW-1:0] id, od;
  logic [1:0][CW-1:0] ic, oc;
  logic [1:0][1:0] occ;
  logic [3:0]  sc0;
  logic [31:0] sc1;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CTRL_CLR(CLR), .SKID(1'b0), .DATA_CLR(1'b0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_ctrl(ic[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]),
    .occupancy(occ[0]), .stall_cnt(sc0));

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .CTRL_CLR(CLR), .SKID(1'b1), .DATA_CLR(1'b1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_ctrl(ic[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]),
    .occupancy(occ[1]), .stall_cnt(sc1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    iv = '0; ordy = '1; fl = '0; id = '0; ic = '0;
  endtask

  typedef struct {
    bit iv; logic [DW-1:0] d; bit ordy; bit fl;
    bit e_ov; logic [DW-1:0] e_od; bit cd; bit e_ir; logic [1:0] e_occ;
  } vec_t;
  vec_t tbl[$];

  // Reference model: a FIFO of beats per instance plus saturating stall counts.
  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } beat_t;
  beat_t mq[2][2];
  int    mn[2];
  bit    rdy1;
  longint mcnt[2];

  initial begin
    idle();
    #1 rst = 1'b1;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ov%0d", k), ov[k], 0);
      chk($sformatf("rst_oc%0d", k), oc[k], CLR);
      chk($sformatf("rst_od%0d", k), od[k], 0);
      chk($sformatf("rst_occ%0d", k), occ[k], 0);
      chk($sformatf("rst_ir%0d", k), ir[k], 1);
    end
    chk("rst_sc0", sc0, 0);
    chk("rst_sc1", sc1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back stream through the skid stage.
    for (int i = 0; i < 10; i++) begin
      iv[1] = (i < 8); id[1] = DW'(i + 1); ic[1] = CW'(i + 1); ordy[1] = 1'b1;
      #1;
      if (i >= 1 && i <= 8) begin
        chk("strm_ov", ov[1], 1);
        chk("strm_od", od[1], i);
        chk("strm_oc", oc[1], i);
        chk("strm_ir", ir[1], 1);
      end else begin
        chk("strm_idle_ov", ov[1], 0);
        chk("strm_idle_oc", oc[1], CLR);
      end
      cyc();
    end
    idle();

    // Backpressure fill/drain, then flushes from FULL and from ONE.
    tbl.push_back('{1, 16'h1A01, 0, 0, 0, 16'h0000, 0, 1, 0});
    tbl.push_back('{1, 16'h2B02, 0, 0, 1, 16'h1A01, 1, 1, 1});
    tbl.push_back('{1, 16'h3C03, 0, 0, 1, 16'h1A01, 1, 0, 2});
    tbl.push_back('{1, 16'h3C03, 1, 0, 1, 16'h1A01, 1, 0, 2});
    tbl.push_back('{1, 16'h3C03, 1, 0, 1, 16'h2B02, 1, 1, 1});
    tbl.push_back('{0, 16'h0000, 1, 0, 1, 16'h3C03, 1, 1, 1});
    tbl.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0});
    tbl.push_back('{1, 16'h4D11, 0, 0, 0, 16'h0000, 0, 1, 0});
    tbl.push_back('{1, 16'h4D12, 0, 0, 1, 16'h4D11, 1, 1, 1});
    tbl.push_back('{1, 16'h4D13, 0, 1, 1, 16'h4D11, 1, 0, 2});
    tbl.push_back('{1, 16'h5E14, 0, 0, 0, 16'h0000, 1, 1, 0});
    tbl.push_back('{1, 16'h6F15, 1, 1, 1, 16'h5E14, 1, 1, 1});
    tbl.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0});
    tbl.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      iv[1] = tbl[i].iv; id[1] = tbl[i].d; ic[1] = tbl[i].d[7:0];
      ordy[1] = tbl[i].ordy; fl[1] = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_ov", i), ov[1], tbl[i].e_ov);
      chk($sformatf("tbl%0d_ir", i), ir[1], tbl[i].e_ir);
      chk($sformatf("tbl%0d_occ", i), occ[1], tbl[i].e_occ);
      chk($sformatf("tbl%0d_oc", i), oc[1], tbl[i].e_ov ? tbl[i].e_od[7:0] : CLR);
      if (tbl[i].cd) chk($sformatf("tbl%0d_od", i), od[1], tbl[i].e_od);
      cyc();
    end
    idle();

    // Single-register stage: combinational ready drop, long stall, saturation, flush keeps count.
    iv[0] = 1'b1; id[0] = 16'h0055; ic[0] = 8'h55; ordy[0] = 1'b0;
    #1 chk("s0_load_ir", ir[0], 1);
    cyc();
    for (int s = 0; s < 20; s++) begin
      iv[0] = 1'b1; id[0] = 16'h0066; ic[0] = 8'h66; ordy[0] = 1'b0;
      #1;
      chk("s0_stall_ir", ir[0], 0);
      chk("s0_stall_ov", ov[0], 1);
      chk("s0_stall_od", od[0], 16'h0055);
      chk("s0_stall_oc", oc[0], 8'h55);
      chk("s0_stall_cnt", sc0, (s > 15) ? 15 : s);
      cyc();
    end
    iv[0] = 1'b0; fl[0] = 1'b1;
    #1 chk("s0_sat_cnt", sc0, 15);
    cyc();
    fl[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    chk("s0_fl_ov", ov[0], 0);
    chk("s0_fl_oc", oc[0], CLR);
    chk("s0_fl_od_kept", od[0], 16'h0055);
    chk("s0_fl_ir", ir[0], 1);
    chk("s0_fl_cnt", sc0, 15);
    idle();
    cyc();

    // Asynchronous reset while the skid stage is full and stalled.
    iv[1] = 1'b1; id[1] = 16'h7001; ic[1] = 8'h71; ordy[1] = 1'b0;
    cyc();
    id[1] = 16'h7002; ic[1] = 8'h72;
    cyc();
    iv[1] = 1'b0;
    #1;
    chk("ar_pre_occ", occ[1], 2);
    chk("ar_pre_ov", ov[1], 1);
    rst = 1'b1;
    #1;
    chk("ar_ov", ov[1], 0);
    chk("ar_oc", oc[1], CLR);
    chk("ar_od", od[1], 0);
    chk("ar_occ", occ[1], 0);
    chk("ar_ir", ir[1], 1);
    chk("ar_sc1", sc1, 0);
    chk("ar_sc0", sc0, 0);
    rst = 1'b0;
    idle();
    @(negedge clk);

    // Randomized traffic against the FIFO model.
    mn = '{0, 0}; rdy1 = 1'b1; mcnt = '{0, 0};
    for (int t = 0; t < 1500; t++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = ($urandom % 4) != 0;
        ordy[k] = ($urandom % 3) != 0;
        fl[k] = ($urandom % 40) == 0;
        id[k] = DW'($urandom);
        ic[k] = CW'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        bit e_ir, ix, ox;
        e_ir = (k == 0) ? (ordy[0] || mn[0] == 0) : rdy1;
        chk($sformatf("rnd_ov%0d", k), ov[k], mn[k] > 0);
        chk($sformatf("rnd_occ%0d", k), occ[k], mn[k]);
        chk($sformatf("rnd_ir%0d", k), ir[k], e_ir);
        chk($sformatf("rnd_oc%0d", k), oc[k], (mn[k] > 0) ? mq[k][0].c : CLR);
        if (mn[k] > 0) chk($sformatf("rnd_od%0d", k), od[k], mq[k][0].d);
        chk($sformatf("rnd_cnt%0d", k), (k == 0) ? 64'(sc0) : 64'(sc1), mcnt[k]);
        ix = iv[k] && e_ir;
        ox = (mn[k] > 0) && ordy[k];
        if (mn[k] > 0 && !ordy[k])
          mcnt[k] = (mcnt[k] == ((k == 0) ? 64'd15 : 64'hFFFF_FFFF)) ? mcnt[k] : mcnt[k] + 1;
        if (fl[k]) mn[k] = 0;
        else begin
          if (ox) begin mq[k][0] = mq[k][1]; mn[k]--; end
          if (ix) begin mq[k][mn[k]] = '{d: id[k], c: ic[k]}; mn[k]++; end
        end
        if (k == 1) rdy1 = (mn[1] < 2);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
